// File: rtl/dac_serial_capture.sv
// Receive-side decoder for the 3-wire DAC serial link: oversamples SYNC/SCLK/DIN on dataclk,
// reassembles each frame into pd_mode and word_out, and counts good and malformed frames.
module dac_serial_capture #(
    parameter int unsigned FRAME_BITS  = 24,
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 DAC_SYNC,
    input  logic                 DAC_SCLK,
    input  logic                 DAC_DIN,
    output logic [DATA_BITS-1:0] word_out,
    output logic [1:0]           pd_mode,
    output logic                 word_valid,
    output logic                 frame_error,
    output logic [15:0]          frame_count,
    output logic [7:0]           error_count,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HIGH} state_t;

    logic [SYNC_STAGES-1:0] sync_sr, sclk_sr, din_sr;
    logic                   sync_h, sclk_h;
    logic                   sync_fall, sync_rise, sclk_fall;
    logic                   sync_fall_q, sync_rise_q, sclk_fall_q, din_q;

    state_t                 state, state_n;
    logic [FRAME_BITS-1:0]  shreg, shreg_n, shifted;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_n, bit_cnt_inc;
    logic                   extra_seen, extra_seen_n;
    logic [DATA_BITS-1:0]   word_out_n;
    logic [1:0]             pd_mode_n;
    logic                   word_valid_n, frame_error_n;
    logic [15:0]            frame_count_n;
    logic [7:0]             error_count_n;

    // Presets match an idle link (SYNC and SCLK high) so reset release creates no edges.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            sync_sr <= '1;
            sclk_sr <= '1;
            din_sr  <= '0;
            sync_h  <= 1'b1;
            sclk_h  <= 1'b1;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], DAC_SYNC};
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], DAC_SCLK};
            din_sr  <= {din_sr[SYNC_STAGES-2:0], DAC_DIN};
            sync_h  <= sync_sr[SYNC_STAGES-1];
            sclk_h  <= sclk_sr[SYNC_STAGES-1];
        end
    end

    assign sclk_fall = sclk_h & ~sclk_sr[SYNC_STAGES-1];
    assign sync_fall = sync_h & ~sync_sr[SYNC_STAGES-1];
    assign sync_rise = ~sync_h & sync_sr[SYNC_STAGES-1];

    // Edge strobes and data are registered together so they stay aligned into the FSM.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            sclk_fall_q <= 1'b0;
            sync_fall_q <= 1'b0;
            sync_rise_q <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            sclk_fall_q <= sclk_fall;
            sync_fall_q <= sync_fall;
            sync_rise_q <= sync_rise;
            din_q       <= din_sr[SYNC_STAGES-1];
        end
    end

    assign shifted     = {shreg[FRAME_BITS-2:0], din_q};
    assign bit_cnt_inc = bit_cnt + 1'b1;

    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_cnt_n     = bit_cnt;
        extra_seen_n  = extra_seen;
        word_out_n    = word_out;
        pd_mode_n     = pd_mode;
        word_valid_n  = 1'b0;
        frame_error_n = 1'b0;
        frame_count_n = frame_count;
        error_count_n = error_count;

        unique case (state)
            IDLE: begin
                if (sync_fall_q) begin
                    state_n      = SHIFT;
                    shreg_n      = '0;
                    bit_cnt_n    = '0;
                    extra_seen_n = 1'b0;
                end
            end
            SHIFT: begin
                if (sclk_fall_q && bit_cnt_inc == CNT_W'(FRAME_BITS)) begin
                    shreg_n       = shifted;
                    bit_cnt_n     = bit_cnt_inc;
                    word_out_n    = shifted[DATA_BITS-1:0];
                    pd_mode_n     = shifted[DATA_BITS+1:DATA_BITS];
                    word_valid_n  = 1'b1;
                    frame_count_n = frame_count + 1'b1;
                    state_n       = sync_rise_q ? IDLE : WAIT_HIGH;
                end else if (sync_rise_q) begin
                    frame_error_n = 1'b1;
                    if (error_count != '1) error_count_n = error_count + 1'b1;
                    state_n       = IDLE;
                end else if (sclk_fall_q) begin
                    shreg_n   = shifted;
                    bit_cnt_n = bit_cnt_inc;
                end
            end
            WAIT_HIGH: begin
                if (sync_rise_q) begin
                    state_n = IDLE;
                end else if (sclk_fall_q && !extra_seen) begin
                    extra_seen_n  = 1'b1;
                    frame_error_n = 1'b1;
                    if (error_count != '1) error_count_n = error_count + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            extra_seen  <= 1'b0;
            word_out    <= '0;
            pd_mode     <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            extra_seen  <= extra_seen_n;
            word_out    <= word_out_n;
            pd_mode     <= pd_mode_n;
            word_valid  <= word_valid_n;
            frame_error <= frame_error_n;
            frame_count <= frame_count_n;
            error_count <= error_count_n;
            busy        <= (state_n == SHIFT);
        end
    end

endmodule

// File: tb/tb_dac_serial_capture.sv
// Directed bench for dac_serial_capture: a table of frames with hand-computed results,
// plus sequences for latency, simultaneous end-of-frame, saturation, mid-frame reset and wrap.
module tb_dac_serial_capture;

    logic        dataclk = 1'b0;
    logic        reset   = 1'b0;
    logic        DAC_SYNC = 1'b1;
    logic        DAC_SCLK = 1'b1;
    logic        DAC_DIN  = 1'b0;
    logic [15:0] word_out;
    logic [1:0]  pd_mode;
    logic        word_valid, frame_error, busy;
    logic [15:0] frame_count;
    logic [7:0]  error_count;

    dac_serial_capture #(.FRAME_BITS(24), .DATA_BITS(16), .SYNC_STAGES(2)) dut (
        .dataclk(dataclk), .reset(reset),
        .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
        .word_out(word_out), .pd_mode(pd_mode), .word_valid(word_valid),
        .frame_error(frame_error), .frame_count(frame_count),
        .error_count(error_count), .busy(busy)
    );

    always #5 dataclk = ~dataclk;

    int cyc = 0;
    int valid_pulses = 0, err_pulses = 0;
    int valid_cyc = 0, fall_cyc = 0;
    int passed = 0, total = 0;

    always @(posedge dataclk) cyc <= cyc + 1;

    always @(negedge dataclk) begin
        if (word_valid) begin
            valid_pulses = valid_pulses + 1;
            valid_cyc    = cyc;
        end
        if (frame_error) err_pulses = err_pulses + 1;
    end

    typedef struct {
        logic [23:0] frame;
        int          nfalls;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_word;
        logic [1:0]  exp_pd;
        logic [15:0] exp_fcnt;
        logic [7:0]  exp_ecnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total = total + 1;
        if (actual === expected) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge dataclk);
    endtask

    // 8-cycle SCLK period; DIN changes while SCLK is high, sampled on the falling edge.
    task automatic send_frame(input logic [23:0] val, input int nfalls);
        DAC_SYNC = 1'b0;
        tick(4);
        for (int i = 0; i < nfalls; i++) begin
            DAC_DIN  = (i < 24) ? val[23-i] : 1'b0;
            DAC_SCLK = 1'b1;
            tick(4);
            DAC_SCLK = 1'b0;
            if (i == 23) fall_cyc = cyc;
            tick(4);
        end
        DAC_SCLK = 1'b1;
        tick(4);
        DAC_SYNC = 1'b1;
        tick(16);
    endtask

    task automatic clear_pulses();
        valid_pulses = 0;
        err_pulses   = 0;
    endtask

    initial begin
        logic [23:0] sv;

        vecs[0] = '{24'h008000, 24, 1, 0, 16'h8000, 2'd0, 16'd1, 8'd0};
        vecs[1] = '{24'h03FFFF, 24, 1, 0, 16'hFFFF, 2'd3, 16'd2, 8'd0};
        vecs[2] = '{24'h00000A, 24, 1, 0, 16'h000A, 2'd0, 16'd3, 8'd0};
        vecs[3] = '{24'h0ABCDE, 13, 0, 1, 16'h000A, 2'd0, 16'd3, 8'd1};
        vecs[4] = '{24'h01C3A5, 24, 1, 0, 16'hC3A5, 2'd1, 16'd4, 8'd1};
        vecs[5] = '{24'h001234, 25, 1, 1, 16'h1234, 2'd0, 16'd5, 8'd2};
        vecs[6] = '{24'h02BEEF, 24, 1, 0, 16'hBEEF, 2'd2, 16'd6, 8'd2};

        tick(3);
        reset = 1'b1;
        clear_pulses();
        tick(50);
        check("idle_word", word_out, 0);
        check("idle_pd", pd_mode, 0);
        check("idle_fcnt", frame_count, 0);
        check("idle_ecnt", error_count, 0);
        check("idle_busy", busy, 0);
        check("idle_valid_pulses", valid_pulses, 0);
        check("idle_err_pulses", err_pulses, 0);

        for (int v = 0; v < 7; v++) begin
            clear_pulses();
            send_frame(vecs[v].frame, vecs[v].nfalls);
            check($sformatf("v%0d_valid_pulses", v), valid_pulses, vecs[v].exp_valid);
            check($sformatf("v%0d_err_pulses", v), err_pulses, vecs[v].exp_err);
            check($sformatf("v%0d_word", v), word_out, vecs[v].exp_word);
            check($sformatf("v%0d_pd", v), pd_mode, vecs[v].exp_pd);
            check($sformatf("v%0d_fcnt", v), frame_count, vecs[v].exp_fcnt);
            check($sformatf("v%0d_ecnt", v), error_count, vecs[v].exp_ecnt);
            check($sformatf("v%0d_busy", v), busy, 0);
            // Drive cycle to pulse cycle: first sampling edge plus SYNC_STAGES+1
            if (v == 0) check("v0_latency", valid_cyc - fall_cyc, 4);
        end

        // SYNC rises in the same dataclk as the 24th SCLK fall: frame still completes.
        clear_pulses();
        sv = 24'h03A55A;
        DAC_SYNC = 1'b0;
        tick(4);
        for (int i = 0; i < 24; i++) begin
            DAC_DIN  = sv[23-i];
            DAC_SCLK = 1'b1;
            tick(4);
            DAC_SCLK = 1'b0;
            if (i == 23) DAC_SYNC = 1'b1;
            tick(4);
        end
        DAC_SCLK = 1'b1;
        tick(16);
        check("simul_valid_pulses", valid_pulses, 1);
        check("simul_err_pulses", err_pulses, 0);
        check("simul_word", word_out, 16'hA55A);
        check("simul_pd", pd_mode, 3);
        check("simul_fcnt", frame_count, 7);
        check("simul_busy", busy, 0);

        // 260 one-bit aborted frames push error_count from 2 into saturation.
        clear_pulses();
        for (int k = 0; k < 260; k++) send_frame(24'h000000, 1);
        check("sat_err_pulses", err_pulses, 260);
        check("sat_ecnt", error_count, 8'hFF);
        check("sat_word", word_out, 16'hA55A);

        // Reset after bit 10 of a frame.
        clear_pulses();
        sv = 24'h005A5A;
        DAC_SYNC = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            DAC_DIN  = sv[23-i];
            DAC_SCLK = 1'b1;
            tick(4);
            DAC_SCLK = 1'b0;
            tick(4);
        end
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        tick(1);
        check("rst_word", word_out, 0);
        check("rst_fcnt", frame_count, 0);
        check("rst_ecnt", error_count, 0);
        check("rst_busy", busy, 0);
        DAC_SYNC = 1'b1;
        DAC_SCLK = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(20);
        check("rst_no_pulses", valid_pulses + err_pulses, 0);
        send_frame(24'h005A5A, 24);
        check("post_rst_valid_pulses", valid_pulses, 1);
        check("post_rst_err_pulses", err_pulses, 0);
        check("post_rst_word", word_out, 16'h5A5A);
        check("post_rst_fcnt", frame_count, 1);

        // frame_count wraps from 0xFFFF.
        force dut.frame_count = 16'hFFFF;
        tick(1);
        release dut.frame_count;
        clear_pulses();
        send_frame(24'h010F0F, 24);
        check("wrap_valid_pulses", valid_pulses, 1);
        check("wrap_fcnt", frame_count, 0);
        check("wrap_word", word_out, 16'h0F0F);
        check("wrap_pd", pd_mode, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dac_serial_capture.md
Name: dac_serial_capture

Overview:
- Receive-side decoder for the 3-wire DAC serial link (DAC_SYNC / DAC_SCLK / DAC_DIN) produced by the scalable HPF DAC output stage.
- Oversamples the link on dataclk, reassembles each frame into its power-down and 16-bit data fields, and flags malformed frames.
- Serves as the in-fabric loopback checker, so every sample sent to the DAC can be compared against the DAC_register value.

Parameters:
- FRAME_BITS, 24, bits per complete frame; the first bit received is the MSB.
- DATA_BITS, 16, width of the data field held in frame bits [DATA_BITS-1:0].
- SYNC_STAGES, 2, synchronizer depth applied to each serial input.

Ports:
- dataclk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- DAC_SYNC  input  1  frame strobe, active low.
- DAC_SCLK  input  1  serial clock; data is sampled on its falling edge.
- DAC_DIN  input  1  serial data, MSB first.
- word_out  output  16  data field of the last complete frame.
- pd_mode  output  2  frame bits [17:16] of the last complete frame.
- word_valid  output  1  one-cycle pulse when word_out/pd_mode update.
- frame_error  output  1  one-cycle pulse on an aborted or overlong frame.
- frame_count  output  16  count of good frames; wraps 0xFFFF->0x0000.
- error_count  output  8  count of bad frames; saturates at 0xFF.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (reset=0, async): all outputs 0, shift register 0, bit counter 0, state IDLE. Synchronizer flops preset to SYNC=1, SCLK=1, DIN=0 so that leaving reset produces no false edges.
- Inputs: each passes through a SYNC_STAGES flop chain, then one history flop.
  - sclk_fall = hist & ~sync.
  - sync_fall and sync_rise are derived the same way from DAC_SYNC.
- FSM:
  - IDLE: on sync_fall -> SHIFT; clear bit counter and shift register.
  - SHIFT, on sclk_fall:
    - shift register <= {shreg[FRAME_BITS-2:0], din_sync}; counter += 1.
    - When the counter reaches FRAME_BITS on this edge: register word_out = shreg[15:0] and pd_mode = shreg[17:16] (post-shift value), pulse word_valid, increment frame_count, go to WAIT_HIGH.
  - SHIFT, on sync_rise with counter < FRAME_BITS: pulse frame_error, increment error_count (saturating), go to IDLE. word_out and pd_mode are unchanged.
  - WAIT_HIGH, on sync_rise: go to IDLE.
  - WAIT_HIGH, on an additional sclk_fall while SYNC is still low: pulse frame_error once per frame, increment error_count. The already-latched word stays valid.
- Simultaneous events:
  - sync_rise together with the FRAME_BITS-th sclk_fall in the same cycle: the frame is complete (the shift is taken) and the FSM goes to IDLE directly.
  - sync_fall while in SHIFT cannot occur, because SYNC is already low.
- Latency: word_valid rises on the dataclk edge SYNC_STAGES+1 cycles after the first edge that samples raw SCLK low for the 24th bit (3 cycles at default).
- Input constraint: SCLK high and low phases must each be at least 2 dataclk periods. Faster input is out of spec and is not detected.
- Counter behaviour: frame_count wraps. error_count holds at 0xFF.
- Mid-frame reset: aborts immediately with no pulse. After release, a frame is captured only after a fresh SYNC falling edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle lines (SYNC=1, SCLK=1) for 50 cycles -> all outputs 0; no word_valid.
- Frame 0x00_8000 (24 bits, SCLK period 8 dataclk) -> one word_valid; word_out=0x8000; pd_mode=0; frame_count=1; valid 3 cycles after the 24th raw falling edge.
- Back-to-back frames 0x03_FFFF then 0x00_000A with SYNC high for 2 SCLK periods between them -> two pulses; pd_mode=3 then 0; word_out=0xFFFF then 0x000A; frame_count=2.
- SYNC raised after 13 bits -> frame_error pulse; error_count=1; word_out keeps its previous value; the next full frame decodes correctly.
- 25 SCLK falls in one SYNC-low window containing 0x00_1234 -> word_valid with word_out=0x1234, then one frame_error; error_count increments by 1.
- reset asserted after bit 10, released, then full frame 0x00_5A5A -> no pulse during the aborted frame; the next frame decodes to 0x5A5A. Also preload frame_count to 0xFFFF and send one frame -> frame_count wraps to 0x0000.
